// File: rtl/ifetch_pkg.sv
// Shared core definitions for the RV32I front end.
// Holds widths, opcodes, fetch-stage state and the fetch entry bundle.
package ifetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

  typedef enum logic [1:0] {
    FETCH,
    FLUSH,
    FAULT
  } ifetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_redirect_op(
    input logic [6:0] opc
  );
    return opc inside {OPC_JAL, OPC_JALR, OPC_BRANCH};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO with flush; head is read straight from
// storage flops so the output carries no path from the write side.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 2 * XLEN,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch.sv
// RV32I instruction fetch stage: PC, imem requests, prefetch FIFO.
// Define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ifetch_state_t   state;
  ifetch_state_t   state_n;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] tgt_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   drop_n;
  logic [CW-1:0]   redir_drop;
  logic [CW-1:0]   count;
  logic [CW:0]     pend;
  logic [CW:0]     occ;
  logic            misalign;
  logic            in_fault;
  logic            fault_pend;
  logic            req_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            pop;
  logic            full;
  logic            empty;
  fetch_entry_t    head;
  fetch_entry_t    rsp_entry;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign tgt_pc   = redirect_pc;
  assign misalign = |redirect_pc[1:0];
  assign in_fault = state == FAULT;
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign tgt_pc     = {redirect_pc[XLEN-1:2], 2'b00};
  assign misalign   = 1'b0;
  assign in_fault   = 1'b0;
`endif

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && drop == '0
                    && !redirect_valid;
  assign rsp_drop = imem_rsp_valid && drop != '0;

  // Requests are sequential, so the oldest one sits inflight words back.
  assign rsp_pc    = fetch_pc - (XLEN'(inflight) << 2);
  assign rsp_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  assign pend = {1'b0, drop} + {1'b0, inflight};
  assign occ  = {1'b0, inflight} + {1'b0, count};

  // A response landing with the redirect is already stale.
  assign redir_drop = (imem_rsp_valid && pend != '0)
                      ? CW'(pend - (CW + 1)'(1))
                      : CW'(pend);

  always_comb begin
    drop_n = drop;
    if (redirect_valid)
      drop_n = redir_drop;
    else if (rsp_drop)
      drop_n = drop - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (redirect_valid) begin
      if (misalign)
        state_n = FAULT;
      else if (redir_drop != '0)
        state_n = FLUSH;
      else
        state_n = FETCH;
    end else begin
      unique case (state)
        FLUSH:   if (drop_n == '0) state_n = FETCH;
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = fetch_pc;
    if_valid       = 1'b0;
    if_instr       = '0;
    if_pc          = '0;
    if_fault       = 1'b0;
    pop            = 1'b0;
    unique case (state)
      FETCH: imem_req_valid = !rst && !redirect_valid
                              && !full
                              && occ < (CW + 1)'(FIFO_DEPTH);
      default: ;
    endcase
    if (in_fault) begin
      if_valid = fault_pend;
      if_fault = fault_pend;
      if (fault_pend) begin
        if_pc    = fetch_pc;
        if_instr = NOP_INSTR;
      end
    end else if (!empty) begin
      if_valid = 1'b1;
      if_pc    = head.pc;
      if_instr = head.instr;
      pop      = if_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      inflight   <= '0;
      drop       <= '0;
      fault_pend <= 1'b0;
    end else begin
      drop <= drop_n;
      if (redirect_valid) begin
        fetch_pc   <= tgt_pc;
        inflight   <= '0;
        fault_pend <= misalign;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        unique case ({req_fire, rsp_keep})
          2'b10:   inflight <= inflight + CW'(1);
          2'b01:   inflight <= inflight - CW'(1);
          default: ;
        endcase
        if (in_fault && if_ready) fault_pend <= 1'b0;
      end
    end
  end

  ifetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch with a behavioural in-order imem.
// Follows IFETCH_MISALIGN_TRAP_EN when it is defined for the build.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  always #5 clk = ~clk;

  ifetch #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct packed {
    logic [31:0] ep;
    logic [31:0] a;
  } req_t;

  exp_t        sb[$];
  req_t        pend[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          tk = 0;
  int          first_v = -1;
  int          busy_hits = 0;
  int          hold_cnt;
  logic [31:0] mpc = 32'h0;
  logic [31:0] epoch = 32'h0;
  bit          in_fault = 0;
  bit          after_redir = 0;
  bit          prev_hold_if = 0;
  bit          prev_req = 0;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic [31:0] prev_addr;
  bit          want_first = 0;
  logic [31:0] first_pop;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic tick(
    input bit          redir,
    input logic [31:0] rpc,
    input bit          rdy,
    input bit          mrdy,
    input bit          rsp_en,
    input bit          busy
  );
    bit   r;
    bit   stale;
    exp_t e;
    req_t q;
    @(negedge clk);
    r = redir || (busy && if_valid && rsp_en
                  && pend.size() > 0);
    if (busy && r) busy_hits++;
    redirect_valid = r;
    redirect_pc    = r ? rpc : 32'h0;
    if_ready       = rdy;
    imem_req_ready = mrdy;
    imem_rsp_valid = rsp_en && pend.size() > 0;
    imem_rsp_data  = imem_rsp_valid ? mem_word(pend[0].a) : 32'h0;
    #1;
    if (first_v < 0 && if_valid) first_v = tk;
    tk++;
    if (after_redir)
      check("post_redirect_valid", if_valid, in_fault);
    if (prev_hold_if) begin
      check("hold_valid", if_valid, 1);
      check("hold_pc", if_pc, prev_pc);
      check("hold_instr", if_instr, prev_instr);
    end
    if (prev_req && !r) begin
      check("req_hold_valid", imem_req_valid, 1);
      check("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (in_fault) check("fault_noreq", imem_req_valid, 0);
    if (!in_fault)
      check("inflight_bound",
            32'(pend.size() + sb.size() <= DEPTH), 1);
    stale = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) stale = 1;
    if (r) begin
      check("redirect_noreq", imem_req_valid, 0);
      sb.delete();
      epoch++;
`ifdef IFETCH_MISALIGN_TRAP_EN
      in_fault = rpc[1:0] != 2'b00;
      mpc = rpc;
      if (in_fault) sb.push_back('{1'b1, rpc, NOP_INSTR});
`else
      mpc = {rpc[31:2], 2'b00};
`endif
    end else if (if_valid && if_ready) begin
      if (sb.size() == 0) begin
        check("spurious_valid", if_valid, 0);
      end else begin
        e = sb.pop_front();
        check("out_pc", if_pc, e.pc);
        check("out_instr", if_instr, e.instr);
        check("out_fault", if_fault, e.fault);
        if (want_first) begin
          first_pop  = if_pc;
          want_first = 0;
        end
      end
    end
    if (imem_rsp_valid) begin
      q = pend.pop_front();
      if (!r && q.ep == epoch)
        sb.push_back('{1'b0, q.a, mem_word(q.a)});
    end
    if (imem_req_valid)
      check("req_while_stale", 32'(stale), 0);
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, mpc);
      pend.push_back('{epoch, mpc});
      mpc += 32'd4;
    end
    after_redir  = r;
    prev_hold_if = if_valid && !if_ready && !r;
    prev_pc      = if_pc;
    prev_instr   = if_instr;
    prev_req     = imem_req_valid && !imem_req_ready;
    prev_addr    = imem_req_addr;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_fault", if_fault, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // startup, memory always ready, one-cycle responses
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 1, 1, 0);
    check("first_valid_cycle", first_v, 2);

    // decode stalls, then drains in order
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 1, 1, 0);

    // two requests in flight, then redirect
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 0, 0);
    check("two_in_flight", pend.size(), 2);
    want_first = 1;
    tick(1, 32'h100, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 1, 1, 0);
    check("first_after_redirect", first_pop, 32'h100);

    // redirect with response and if_ready in the same cycle
    for (int i = 0; i < 8; i++)
      tick(0, 32'h200, 1, 1, 1, busy_hits == 0);
    check("busy_redirect_hit", busy_hits, 1);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 1, 1, 0);

    // memory back-pressure
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 1, 0);
    hold_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 0, 1, 0);
      if (prev_req) hold_cnt++;
    end
    check("req_held_cycles", hold_cnt, 5);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 1, 1, 0);

    // misaligned redirect target
    want_first = 1;
    tick(1, 32'h102, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 1, 1, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("fault_first_pc", first_pop, 32'h102);
    check("fault_consumed", if_valid, 0);
    check("fault_quiet_req", imem_req_valid, 0);
`else
    check("aligned_first_pc", first_pop, 32'h100);
`endif
    tick(1, 32'h300, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 1, 1, 0);

    // random traffic
    for (int i = 0; i < 80; i++)
      tick($urandom_range(0, 11) == 0,
           32'($urandom_range(0, 1023)) << 2,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, 0);

    // reset mid-operation
    @(negedge clk);
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("midrst_if_valid", if_valid, 0);
    check("midrst_req_addr", imem_req_addr, 32'h0);
    pend.delete();
    sb.delete();
    mpc          = 32'h0;
    epoch++;
    in_fault     = 0;
    after_redir  = 0;
    prev_hold_if = 0;
    prev_req     = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    want_first = 1;
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 1, 1, 0);
    check("post_reset_first_pc", first_pop, 32'h0);

    for (int i = 0; i < 6; i++) tick(0, 0, 1, 0, 1, 0);
    check("drain_sb", sb.size(), 0);
    check("drain_pend", pend.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
